// File: rtl/cfa_pkg.sv
// Shared constants and tap-index helper for the CFA 5x5 window interface.
// Pure declarations; no logic, no latency.
// Used by both the window producer and the equation blocks that consume it.
package cfa_pkg;

  // Default pixel width (one eRtC tap)
  localparam int PIX_W    = 12;
  // Window edge length in pixels
  localparam int WIN_N    = 5;
  localparam int WIN_TAPS = WIN_N * WIN_N;
  // Flattened window bus width at the default pixel width
  localparam int WIN_W    = WIN_TAPS * PIX_W;

  // Tap slot of eRtC on the flattened bus; R and C are 1-based (1 = oldest)
  function automatic int tap_idx(input int r, input int c);
    return (r - 1) * WIN_N + (c - 1);
  endfunction

endpackage

// File: rtl/cfa_line_buf.sv
// Single-line pixel delay of DEPTH entries, single-port, read-before-write.
// Combinational read: dout_o shows the entry at addr_i before this cycle's write.
// No backpressure; a write happens on every cycle with en_i high.
module cfa_line_buf #(
  parameter int DEPTH = 640,
  parameter int W     = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o
);

  // Contents are deliberately not reset; the window gating never exposes stale data.
  logic [W-1:0] mem_q [DEPTH];

  // Write the incoming pixel into its column slot
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  // Old value at this column is the pixel from exactly one line (DEPTH accepts) earlier
  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/cfa_window_gen.sv
// Raster Bayer stream -> 5x5 neighbourhood producer for the CFA equation blocks.
// Latency: start pulses 1 clk after the pixel completing an interior window.
// No backpressure; pix_valid=0 simply holds the window and suppresses start.
module cfa_window_gen #(
  parameter int PIX_W = cfa_pkg::PIX_W,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic               sof,
  output logic [25*PIX_W-1:0] win_out,
  output logic               start,
  output logic               frame_done
);
  import cfa_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(WIN_N - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(WIN_N - 1);
  localparam int NLB = WIN_N - 1;

  logic             accept;
  logic [CW-1:0]    col_q, col_d, col_cur;
  logic [RW-1:0]    row_q, row_d, row_cur;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic [PIX_W-1:0] win_q [WIN_N][WIN_N];
  logic [PIX_W-1:0] win_d [WIN_N][WIN_N];
  logic [PIX_W-1:0] col_new [WIN_N];
  logic [PIX_W-1:0] lb_din  [NLB];
  logic [PIX_W-1:0] lb_dout [NLB];

  // Reset takes priority over a coincident pixel, so that pixel is dropped
  assign accept = pix_valid & ~rst;

  // A qualified sof restarts the raster at (0,0) regardless of the counters
  always_comb begin
    col_cur = col_q;
    row_cur = row_q;
    if (sof) begin
      col_cur = '0;
      row_cur = '0;
    end
  end

  // Four cascaded line delays: buffer i returns the pixel from line r-1-i at this column
  assign lb_din[0] = pix_in;
  for (genvar i = 1; i < NLB; i++) begin : g_lb_chain
    assign lb_din[i] = lb_dout[i-1];
  end

  for (genvar i = 0; i < NLB; i++) begin : g_lb
    cfa_line_buf #(
      .DEPTH (IMG_W),
      .W     (PIX_W),
      .AW    (CW)
    ) u_lb (
      .clk    (clk),
      .en_i   (accept),
      .addr_i (col_cur),
      .din_i  (lb_din[i]),
      .dout_o (lb_dout[i])
    );
  end

  // New right-hand column, oldest line (row index 0) first, current pixel last
  always_comb begin
    for (int r = 0; r < NLB; r++) begin
      col_new[r] = lb_dout[NLB-1-r];
    end
    col_new[WIN_N-1] = pix_in;
  end

  // Raster position, window strobe and end-of-frame strobe
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    if (accept) begin
      // With col>=4 all five columns come from the same line
      start_d = (row_cur >= ROW_MIN) && (col_cur >= COL_MIN);
      if (col_cur == COL_LAST) begin
        col_d = '0;
        if (row_cur == ROW_LAST) begin
          row_d  = '0;
          done_d = 1'b1;
        end else begin
          row_d = row_cur + RW'(1);
        end
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
  end

  // Shift the 5x5 array one column left on each accepted pixel
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < WIN_N; r++) begin
        for (int c = 0; c < WIN_N - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][WIN_N-1] = col_new[r];
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < WIN_N; r++) begin
        for (int c = 0; c < WIN_N; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      start_q <= start_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  // Flatten the array onto the tap bus: eRtC at slot (R-1)*5+(C-1)
  always_comb begin
    win_out = '0;
    for (int r = 0; r < WIN_N; r++) begin
      for (int c = 0; c < WIN_N; c++) begin
        win_out[PIX_W*tap_idx(r+1, c+1) +: PIX_W] = win_q[r][c];
      end
    end
  end

  assign start      = start_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_cfa_window_gen.sv
// Self-checking bench for cfa_window_gen at IMG_W=8, IMG_H=6.
// Reference model stores the received frame as a 2-D image and builds windows from coordinates.
module tb_cfa_window_gen;

  localparam int PW = 12;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int WW = 25 * PW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pix_in;
  logic          pix_valid;
  logic          sof;
  logic [WW-1:0] win_out;
  logic          start;
  logic          frame_done;

  always #5 clk = ~clk;

  cfa_window_gen #(
    .PIX_W (PW),
    .IMG_W (IW),
    .IMG_H (IH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .win_out    (win_out),
    .start      (start),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raster position and image of the frame currently arriving
  int            m_row = 0;
  int            m_col = 0;
  logic [PW-1:0] m_img [IH][IW];
  logic          exp_start = 1'b0;
  logic          exp_fd    = 1'b0;
  logic [WW-1:0] exp_win   = '0;
  logic [WW-1:0] clean_win [$];

  function automatic logic [PW-1:0] tap(input logic [WW-1:0] w, input int r, input int c);
    logic [WW-1:0] t;
    t = w >> (PW * ((r - 1) * 5 + (c - 1)));
    return t[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] ramp(input int idx);
    int v;
    v = 16 * (idx / IW) + (idx % IW);
    return v[PW-1:0];
  endfunction

  // Drive one cycle at the falling edge, update the model, return after the next falling edge
  task automatic step(input logic [PW-1:0] v, input logic vld, input logic s, input logic r);
    pix_in    = v;
    pix_valid = vld;
    sof       = s;
    rst       = r;
    if (r) begin
      m_row = 0; m_col = 0;
      exp_start = 1'b0; exp_fd = 1'b0; exp_win = '0;
    end else if (vld) begin
      if (s) begin m_row = 0; m_col = 0; end
      m_img[m_row][m_col] = v;
      exp_start = (m_row >= 4) && (m_col >= 4);
      exp_fd    = (m_row == IH - 1) && (m_col == IW - 1);
      if (exp_start) begin
        for (int rr = 1; rr <= 5; rr++)
          for (int cc = 1; cc <= 5; cc++)
            exp_win[PW*((rr-1)*5+(cc-1)) +: PW] = m_img[m_row-5+rr][m_col-5+cc];
      end
      m_col++;
      if (m_col == IW) begin
        m_col = 0;
        m_row++;
        if (m_row == IH) m_row = 0;
      end
    end else begin
      exp_start = 1'b0;
      exp_fd    = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (win_out !== '0) begin n_fail++; $display("FAIL reset_win: got %h expected 0", win_out); end
  endtask

  task automatic test_first_frame();
    int first_idx = -1, n_start = 0, n_fd = 0, fd_idx = -1;
    logic [WW-1:0] first_w = '0, last_w = '0;
    clean_win.delete();
    for (int i = 0; i < IW * IH; i++) begin
      step(ramp(i), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (start !== exp_start) begin n_fail++; $display("FAIL frame_start idx %0d: got %b expected %b", i, start, exp_start); end
      n_checks++;
      if (frame_done !== exp_fd) begin n_fail++; $display("FAIL frame_done idx %0d: got %b expected %b", i, frame_done, exp_fd); end
      if (start) begin
        n_start++;
        if (first_idx < 0) begin first_idx = i; first_w = win_out; end
        last_w = win_out;
        clean_win.push_back(win_out);
        n_checks++;
        if (win_out !== exp_win) begin n_fail++; $display("FAIL frame_win idx %0d: got %h expected %h", i, win_out, exp_win); end
      end
      if (frame_done) begin n_fd++; fd_idx = i; end
    end
    n_checks++; if (first_idx != 36) begin n_fail++; $display("FAIL first_start_idx: got %0d expected 36", first_idx); end
    n_checks++; if (n_start != 8) begin n_fail++; $display("FAIL start_count: got %0d expected 8", n_start); end
    n_checks++; if (n_fd != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d expected 1", n_fd); end
    n_checks++; if (fd_idx != 47) begin n_fail++; $display("FAIL frame_done_idx: got %0d expected 47", fd_idx); end
    n_checks++; if (tap(first_w, 1, 1) !== 12'd0)  begin n_fail++; $display("FAIL first_e1t1: got %0d expected 0", tap(first_w, 1, 1)); end
    n_checks++; if (tap(first_w, 3, 3) !== 12'd34) begin n_fail++; $display("FAIL first_e3t3: got %0d expected 34", tap(first_w, 3, 3)); end
    n_checks++; if (tap(first_w, 5, 5) !== 12'd68) begin n_fail++; $display("FAIL first_e5t5: got %0d expected 68", tap(first_w, 5, 5)); end
    n_checks++; if (tap(first_w, 1, 5) !== 12'd4)  begin n_fail++; $display("FAIL first_e1t5: got %0d expected 4", tap(first_w, 1, 5)); end
    n_checks++; if (tap(first_w, 5, 1) !== 12'd64) begin n_fail++; $display("FAIL first_e5t1: got %0d expected 64", tap(first_w, 5, 1)); end
    n_checks++; if (tap(last_w, 5, 5) !== 12'd87)  begin n_fail++; $display("FAIL last_e5t5: got %0d expected 87", tap(last_w, 5, 5)); end
    n_checks++; if (tap(last_w, 1, 1) !== 12'd19)  begin n_fail++; $display("FAIL last_e1t1: got %0d expected 19", tap(last_w, 1, 1)); end
  endtask

  task automatic test_hold();
    logic [WW-1:0] held;
    for (int i = 0; i < IW * IH; i++) begin
      if (i == 37) begin
        held = win_out;
        // Idle cycles; the sof here has no pix_valid and must be ignored
        step(12'hABC, 1'b0, 1'b1, 1'b0);
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL hold_start_idle1: got %b expected 0", start); end
        n_checks++; if (win_out !== held) begin n_fail++; $display("FAIL hold_win_idle1: got %h expected %h", win_out, held); end
        step(12'h123, 1'b0, 1'b0, 1'b0);
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL hold_start_idle2: got %b expected 0", start); end
        n_checks++; if (win_out !== held) begin n_fail++; $display("FAIL hold_win_idle2: got %h expected %h", win_out, held); end
      end
      step(ramp(i), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (start !== exp_start) begin n_fail++; $display("FAIL hold_frame_start idx %0d: got %b expected %b", i, start, exp_start); end
      if (start && win_out !== exp_win) begin
        n_fail++; $display("FAIL hold_frame_win idx %0d: got %h expected %h", i, win_out, exp_win);
      end
      if (i == 37) begin
        n_checks++; if (tap(win_out, 5, 5) !== 12'd69) begin n_fail++; $display("FAIL hold_next_e5t5: got %0d expected 69", tap(win_out, 5, 5)); end
      end
    end
  endtask

  task automatic test_sof_restart();
    int k = 0;
    for (int i = 0; i < 3 * IW + 2; i++) step(ramp(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < IW * IH; i++) begin
      step(ramp(i), 1'b1, (i == 0), 1'b0);
      n_checks++;
      if (start !== exp_start) begin n_fail++; $display("FAIL sof_start idx %0d: got %b expected %b", i, start, exp_start); end
      if (start) begin
        n_checks++;
        if (k >= clean_win.size() || win_out !== clean_win[k]) begin
          n_fail++; $display("FAIL sof_win k %0d: got %h expected clean-run window", k, win_out);
        end
        k++;
      end
    end
    n_checks++; if (k != 8) begin n_fail++; $display("FAIL sof_win_count: got %0d expected 8", k); end
  endtask

  task automatic test_reset_mid();
    int first_idx = -1;
    logic [WW-1:0] first_w = '0;
    for (int i = 0; i < 38; i++) step(ramp(i), 1'b1, 1'b0, 1'b0);
    step(ramp(38), 1'b1, 1'b0, 1'b1);
    n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: got %b expected 0", start); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (win_out !== '0) begin n_fail++; $display("FAIL rstmid_win: got %h expected 0", win_out); end
    for (int i = 0; i < IW * IH; i++) begin
      step(ramp(i), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (start !== exp_start) begin n_fail++; $display("FAIL rstmid_frame_start idx %0d: got %b expected %b", i, start, exp_start); end
      if (start && first_idx < 0) begin first_idx = i; first_w = win_out; end
    end
    n_checks++; if (first_idx != 36) begin n_fail++; $display("FAIL rstmid_first_idx: got %0d expected 36", first_idx); end
    n_checks++; if (tap(first_w, 3, 3) !== 12'd34) begin n_fail++; $display("FAIL rstmid_e3t3: got %0d expected 34", tap(first_w, 3, 3)); end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < IW * IH; i++) begin
        step(ramp(i), 1'b1, 1'b0, 1'b0);
        if (start) begin
          n_checks++;
          if (k >= 16 || win_out !== clean_win[k % 8]) begin
            n_fail++; $display("FAIL b2b_win frame %0d k %0d: got %h expected clean-run window", f, k, win_out);
          end
          k++;
        end
      end
    end
    n_checks++; if (k != 16) begin n_fail++; $display("FAIL b2b_win_count: got %0d expected 16", k); end
  endtask

  task automatic test_random();
    logic [WW-1:0] prev;
    logic vld, s;
    logic [PW-1:0] v;
    for (int n = 0; n < 700; n++) begin
      prev = win_out;
      vld  = ($urandom_range(0, 3) != 0);
      s    = vld && ($urandom_range(0, 59) == 0);
      v    = PW'($urandom);
      step(v, vld, s, 1'b0);
      n_checks++;
      if (start !== exp_start) begin n_fail++; $display("FAIL rand_start n %0d: got %b expected %b", n, start, exp_start); end
      n_checks++;
      if (frame_done !== exp_fd) begin n_fail++; $display("FAIL rand_frame_done n %0d: got %b expected %b", n, frame_done, exp_fd); end
      if (start) begin
        n_checks++;
        if (win_out !== exp_win) begin n_fail++; $display("FAIL rand_win n %0d: got %h expected %h", n, win_out, exp_win); end
      end
      if (!vld) begin
        n_checks++;
        if (win_out !== prev) begin n_fail++; $display("FAIL rand_hold n %0d: got %h expected %h", n, win_out, prev); end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_in    = '0;
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_hold();
    test_sof_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
